// File: rtl/clock_div_monitor.sv
// Period checker for a divided clock, measured in reference-clock cycles.
// Reports each period and tracks lock, error count and loss of the clock.
module clock_div_monitor #(
    parameter int CNT_W    = 16,
    parameter int TOL      = 1,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_clock_mon,
    input  logic [7:0]       io_div,
    input  logic             io_clear,
    output logic [CNT_W-1:0] io_period,
    output logic             io_period_valid,
    output logic             io_locked,
    output logic             io_timeout,
    output logic [15:0]      io_err_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(UNLOCK_N + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_N - 1);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(UNLOCK_N - 1);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W + 1)'(TOL);

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       div_q;
    state_t           state;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;
    logic             started;
    logic             div_chg;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   div_ext;
    logic [CNT_W:0]   diff;
    logic             good;
    logic             report;
    logic             err_inc;
    logic             expired;

    assign rise    = s2 & ~s3;
    assign div_chg = (io_div != div_q);
    assign cnt_ext = {1'b0, cnt};
    assign div_ext = (CNT_W + 1)'(div_q);
    assign good    = (diff <= TOL_W);
    assign expired = !rise && (cnt == TO_LAST);

    // A period is reported only when a previous rise marked its start;
    // with a zero ratio the FSM idles, so the started flag provides that.
    assign report = rise &&
                    ((state != IDLE) || ((div_q == 8'd0) && started));

    assign err_inc = rise && !div_chg && (state == LOCKED) && !good &&
                     (io_err_count != 16'hFFFF);

    assign io_locked = (state == LOCKED);

    // Absolute period error, computed one bit wider so it cannot wrap
    always_comb begin
        diff = '0;
        if (cnt_ext >= div_ext) begin
            diff = cnt_ext - div_ext;
        end else begin
            diff = div_ext - cnt_ext;
        end
    end

    // Three-flop synchroniser for the asynchronous monitored clock
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= io_clock_mon;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Period counter restarts at each rise and saturates when the clock stops
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Latch the finished period and pulse valid for one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            io_period       <= '0;
            io_period_valid <= 1'b0;
        end else begin
            io_period_valid <= report;
            if (report) begin
                io_period <= cnt;
            end
        end
    end

    // Lock state machine; a ratio change restarts acquisition
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            div_q    <= io_div;
        end else if (div_chg) begin
            div_q    <= io_div;
            state    <= IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (rise) begin
            unique case (state)
                IDLE: begin
                    if (div_q != 8'd0) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (!good) begin
                        good_cnt <= '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        state    <= LOCKED;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else begin
                        good_cnt <= good_cnt + GW'(1);
                    end
                end
                LOCKED: begin
                    if (good) begin
                        bad_cnt <= '0;
                    end else if (bad_cnt == BAD_LAST) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else begin
                        bad_cnt <= bad_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end else if (expired) begin
            state <= IDLE;
        end
    end

    // Sticky timeout flag, cleared by the next monitored rise
    always_ff @(posedge clock) begin
        if (reset) begin
            io_timeout <= 1'b0;
            started    <= 1'b0;
        end else if (rise) begin
            io_timeout <= 1'b0;
            started    <= 1'b1;
        end else if (expired) begin
            io_timeout <= 1'b1;
            started    <= 1'b0;
        end
    end

    // Saturating count of bad periods while locked; clear has priority
    always_ff @(posedge clock) begin
        if (reset) begin
            io_err_count <= '0;
        end else if (io_clear) begin
            io_err_count <= '0;
        end else if (err_inc) begin
            io_err_count <= io_err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_clock_div_monitor.sv
// Directed bench for clock_div_monitor: lock, errors, timeout,
// ratio change, jitter tolerance, clear priority and reset.
module tb_clock_div_monitor;

    localparam int TO = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_clock_mon = 1'b0;
    logic [7:0]  io_div = 8'd4;
    logic        io_clear = 1'b0;
    logic [15:0] io_period;
    logic        io_period_valid;
    logic        io_locked;
    logic        io_timeout;
    logic [15:0] io_err_count;
    logic [15:0] t0_period;
    logic        t0_valid;
    logic        t0_locked;
    logic        t0_timeout;
    logic [15:0] t0_err;

    int n_checks = 0;
    int n_errors = 0;
    int pv_cnt = 0;
    int pv0;
    logic [15:0] last_period = '0;

    clock_div_monitor #(
        .CNT_W(16), .TOL(1), .LOCK_N(4), .UNLOCK_N(2), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .io_clock_mon(io_clock_mon),
        .io_div(io_div), .io_clear(io_clear), .io_period(io_period),
        .io_period_valid(io_period_valid), .io_locked(io_locked),
        .io_timeout(io_timeout), .io_err_count(io_err_count)
    );

    clock_div_monitor #(
        .CNT_W(16), .TOL(0), .LOCK_N(4), .UNLOCK_N(2), .TIMEOUT(TO)
    ) dut0 (
        .clock(clock), .reset(reset), .io_clock_mon(io_clock_mon),
        .io_div(io_div), .io_clear(io_clear), .io_period(t0_period),
        .io_period_valid(t0_valid), .io_locked(t0_locked),
        .io_timeout(t0_timeout), .io_err_count(t0_err)
    );

    always #5 clock = ~clock;

    // Record reported periods for later checks
    always @(negedge clock) begin
        if (io_period_valid) begin
            pv_cnt = pv_cnt + 1;
            last_period = io_period;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One monitored period of p reference cycles, starting at a negedge
    task automatic mon_period(input int p);
        int h;
        h = p / 2;
        io_clock_mon = 1'b1;
        repeat (h) @(negedge clock);
        io_clock_mon = 1'b0;
        repeat (p - h) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(io_period), 32'd0);
        chk({tag, "_valid"}, 32'(io_period_valid), 32'd0);
        chk({tag, "_locked"}, 32'(io_locked), 32'd0);
        chk({tag, "_timeout"}, 32'(io_timeout), 32'd0);
        chk({tag, "_err"}, 32'(io_err_count), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;

        // Steady period 4 at div 4: locks on the 5th rise
        repeat (4) mon_period(4);
        chk("lock_before5", 32'(io_locked), 32'd0);
        mon_period(4);
        chk("lock_at5", 32'(io_locked), 32'd1);
        chk("pv_count", 32'(pv_cnt), 32'd4);
        chk("period4", 32'(last_period), 32'd4);
        chk("err_clean", 32'(io_err_count), 32'd0);

        // Single bad period while locked
        mon_period(7);
        mon_period(4);
        chk("one_bad_err", 32'(io_err_count), 32'd1);
        chk("one_bad_lock", 32'(io_locked), 32'd1);
        chk("period7", 32'(last_period), 32'd7);
        mon_period(4);
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        chk("clear", 32'(io_err_count), 32'd0);

        // Two consecutive bad periods drop lock
        mon_period(7);
        mon_period(7);
        chk("bad1_err", 32'(io_err_count), 32'd1);
        chk("bad1_lock", 32'(io_locked), 32'd1);
        mon_period(4);
        chk("bad2_err", 32'(io_err_count), 32'd2);
        chk("bad2_lock", 32'(io_locked), 32'd0);
        repeat (3) mon_period(4);
        chk("relock3", 32'(io_locked), 32'd0);
        mon_period(4);
        chk("relock4", 32'(io_locked), 32'd1);

        // Stop the monitored clock: timeout TIMEOUT cycles after the rise
        repeat (TO - 3) @(negedge clock);
        chk("to_early", 32'(io_timeout), 32'd0);
        @(negedge clock);
        chk("to_set", 32'(io_timeout), 32'd1);
        chk("to_unlock", 32'(io_locked), 32'd0);
        pv0 = pv_cnt;
        mon_period(4);
        chk("to_clear", 32'(io_timeout), 32'd0);
        chk("to_noreport", 32'(pv_cnt), 32'(pv0));
        repeat (4) mon_period(4);
        chk("to_relock", 32'(io_locked), 32'd1);

        // Ratio change to 6 with the clock still at 4
        io_div = 8'd6;
        @(negedge clock);
        chk("div_unlock", 32'(io_locked), 32'd0);
        repeat (8) mon_period(4);
        chk("div_nolock", 32'(io_locked), 32'd0);
        repeat (4) mon_period(6);
        chk("div6_before5", 32'(io_locked), 32'd0);
        mon_period(6);
        chk("div6_lock", 32'(io_locked), 32'd1);
        chk("period6", 32'(last_period), 32'd6);
        chk("div_err_kept", 32'(io_err_count), 32'd2);

        // Zero ratio: never locks but periods are still reported
        io_div = 8'd0;
        @(negedge clock);
        repeat (6) mon_period(4);
        chk("div0_lock", 32'(io_locked), 32'd0);
        chk("div0_period", 32'(last_period), 32'd4);

        // Jitter 3/5 around div 4
        io_div = 8'd4;
        @(negedge clock);
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mon_period((i % 2) != 0 ? 5 : 3);
        end
        chk("jit_tol1_lock", 32'(io_locked), 32'd1);
        chk("jit_tol1_err", 32'(io_err_count), 32'd0);
        chk("jit_tol0_lock", 32'(t0_locked), 32'd0);

        // Clear in the same cycle as a bad-period increment
        mon_period(7);
        io_clock_mon = 1'b1;
        @(negedge clock);
        @(negedge clock);
        io_clock_mon = 1'b0;
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        chk("clr_wins", 32'(io_err_count), 32'd0);
        chk("clr_lock", 32'(io_locked), 32'd1);
        @(negedge clock);
        mon_period(4);
        mon_period(7);
        mon_period(4);
        chk("pre_rst_err", 32'(io_err_count), 32'd1);
        chk("pre_rst_lock", 32'(io_locked), 32'd1);

        // Reset while locked
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("midrst");
        reset = 1'b0;
        pv0 = pv_cnt;
        mon_period(4);
        chk("rst_noreport", 32'(pv_cnt), 32'(pv0));
        mon_period(4);
        chk("rst_report", 32'(pv_cnt), 32'(pv0 + 1));
        chk("rst_period", 32'(last_period), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
